game_timer: RTL and testbench

GAME_TIMER -- requirements
Module: game_timer

---
 rtl/game_timer.sv | 116 +++++++++++
 tb/tb_game_timer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
// Game timer: counts seconds up toward a limit or down from it, with pause/resume.
// The prescaler divides clk into one-second ticks; tick and expired line up with the cur_time update.
module game_timer #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int TIME_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  resume,
  input  logic                  count_down,
  input  logic [TIME_WIDTH-1:0] limit,
  output logic [TIME_WIDTH-1:0] cur_time,
  output logic                  running,
  output logic                  tick,
  output logic                  expired,
  output logic                  done
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;

  state_t                state, state_next;
  logic [PW-1:0]         presc, presc_next;
  logic [TIME_WIDTH-1:0] time_next;
  logic [TIME_WIDTH-1:0] lim, lim_next;
  logic                  mode, mode_next;
  logic                  tick_next, expired_next;
  logic [TIME_WIDTH-1:0] up_val, dn_val;
  logic                  boundary;

  assign up_val   = cur_time + TIME_WIDTH'(1);
  assign dn_val   = (cur_time == '0) ? '0 : cur_time - TIME_WIDTH'(1);
  assign boundary = (presc == PRESC_LAST);

  // start outranks everything; pause is only honoured in RUN, resume only in PAUSED
  always_comb begin
    state_next   = state;
    presc_next   = presc;
    time_next    = cur_time;
    mode_next    = mode;
    lim_next     = lim;
    tick_next    = 1'b0;
    expired_next = 1'b0;
    if (start) begin
      mode_next  = count_down;
      lim_next   = limit;
      presc_next = '0;
      time_next  = count_down ? limit : '0;
      if (count_down && (limit == '0)) begin
        state_next   = DONE;
        expired_next = 1'b1;
      end else begin
        state_next = RUN;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (pause) begin
            state_next = PAUSED;
          end else if (boundary) begin
            presc_next = '0;
            tick_next  = 1'b1;
            if (mode) begin
              time_next = dn_val;
              if (dn_val == '0) begin
                state_next   = DONE;
                expired_next = 1'b1;
              end
            end else begin
              time_next = up_val;
              // a zero limit means free-running with wrap-around
              if ((lim != '0) && (up_val == lim)) begin
                state_next   = DONE;
                expired_next = 1'b1;
              end
            end
          end else begin
            presc_next = presc + PW'(1);
          end
        end
        PAUSED: begin
          if (resume) state_next = RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      cur_time <= '0;
      mode     <= 1'b0;
      lim      <= '0;
      tick     <= 1'b0;
      expired  <= 1'b0;
    end else begin
      state    <= state_next;
      presc    <= presc_next;
      cur_time <= time_next;
      mode     <= mode_next;
      lim      <= lim_next;
      tick     <= tick_next;
      expired  <= expired_next;
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer (TICKS_PER_SEC=4, TIME_WIDTH=4).
// Expected tick/expired pulses are queued at stimulus time and matched by a negedge monitor.
module tb_game_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       resume = 1'b0;
  logic       count_down = 1'b0;
  logic [3:0] limit = 4'd0;
  logic [3:0] cur_time;
  logic       running, tick, expired, done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [3:0] t;
    logic       tk;
    logic       ex;
    logic       dn;
  } exp_t;

  exp_t sbq[$];

  game_timer #(.TICKS_PER_SEC(4), .TIME_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .resume(resume),
    .count_down(count_down), .limit(limit), .cur_time(cur_time),
    .running(running), .tick(tick), .expired(expired), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic pushExp(input int c, input logic [3:0] t, input logic tk, input logic ex, input logic dn);
    exp_t e;
    e.cyc = c; e.t = t; e.tk = tk; e.ex = ex; e.dn = dn;
    sbq.push_back(e);
  endtask

  // Drives one cycle of requests; call at a negedge, returns at the next negedge.
  task automatic applyStimulus(input logic r, input logic s, input logic p, input logic rs,
                               input logic cd, input logic [3:0] lim);
    reset = r; start = s; pause = p; resume = rs; count_down = cd; limit = lim;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; pause = 1'b0; resume = 1'b0; count_down = 1'b0; limit = 4'd0;
  endtask

  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (tick || expired) begin
      if (sbq.size() == 0) begin
        checkOutput("spurious_pulse", 32'({tick, expired}), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("pulse_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("pulse_time", 32'(cur_time), 32'(e.t));
        checkOutput("pulse_tick", 32'(tick), 32'(e.tk));
        checkOutput("pulse_expired", 32'(expired), 32'(e.ex));
        checkOutput("pulse_done", 32'(done), 32'(e.dn));
      end
    end
  end

  initial begin
    int s, s2, r;
    $display("[TB] game_timer bench start");
    repeat (2) @(negedge clk);
    checkOutput("rst_time", 32'(cur_time), 32'd0);
    checkOutput("rst_running", 32'(running), 32'd0);
    checkOutput("rst_tick", 32'(tick), 32'd0);
    checkOutput("rst_expired", 32'(expired), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("idle_time", 32'(cur_time), 32'd0);
    checkOutput("idle_running", 32'(running), 32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);

    // count up to 3
    s = cyc + 1;
    for (int k = 1; k <= 3; k++) pushExp(s + 4 * k, 4'(k), 1'b1, k == 3, k == 3);
    applyStimulus(0, 1, 0, 0, 0, 4'd3);
    checkOutput("up_running", 32'(running), 32'd1);
    checkOutput("up_load", 32'(cur_time), 32'd0);
    checkOutput("up_no_tick_on_start", 32'(tick), 32'd0);
    waitUntil(s + 14);
    checkOutput("up_done", 32'(done), 32'd1);
    checkOutput("up_running_drop", 32'(running), 32'd0);
    checkOutput("up_final", 32'(cur_time), 32'd3);
    applyStimulus(0, 0, 1, 0, 0, 4'd0);
    applyStimulus(0, 0, 0, 1, 0, 4'd0);
    checkOutput("done_hold", 32'(done), 32'd1);
    checkOutput("done_hold_time", 32'(cur_time), 32'd3);
    checkOutput("done_not_running", 32'(running), 32'd0);
    checkOutput("up_sb_empty", 32'(sbq.size()), 32'd0);

    // count down from 2, then zero-limit count down
    s = cyc + 1;
    pushExp(s + 4, 4'd1, 1'b1, 1'b0, 1'b0);
    pushExp(s + 8, 4'd0, 1'b1, 1'b1, 1'b1);
    applyStimulus(0, 1, 0, 0, 1, 4'd2);
    checkOutput("dn_load", 32'(cur_time), 32'd2);
    checkOutput("dn_running", 32'(running), 32'd1);
    waitUntil(s + 10);
    checkOutput("dn_done", 32'(done), 32'd1);
    checkOutput("dn_final", 32'(cur_time), 32'd0);
    checkOutput("dn_sb_empty", 32'(sbq.size()), 32'd0);
    s = cyc + 1;
    pushExp(s, 4'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(0, 1, 0, 0, 1, 4'd0);
    checkOutput("dn0_done", 32'(done), 32'd1);
    checkOutput("dn0_running", 32'(running), 32'd0);
    @(negedge clk);
    checkOutput("dn0_expired_drop", 32'(expired), 32'd0);
    checkOutput("dn0_sb_empty", 32'(sbq.size()), 32'd0);

    // free-running count up, wraps 15 -> 0
    s = cyc + 1;
    for (int k = 1; k <= 17; k++) pushExp(s + 4 * k, 4'(k), 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1, 0, 0, 0, 4'd0);
    waitUntil(s + 70);
    checkOutput("wrap_time", 32'(cur_time), 32'd1);
    checkOutput("wrap_not_done", 32'(done), 32'd0);
    checkOutput("wrap_running", 32'(running), 32'd1);
    checkOutput("wrap_sb_empty", 32'(sbq.size()), 32'd0);

    // pause on a boundary cycle, resume later
    s = cyc + 1;
    pushExp(s + 4, 4'd1, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1, 0, 0, 0, 4'd9);
    waitUntil(s + 7);
    applyStimulus(0, 0, 1, 0, 0, 4'd0);
    checkOutput("pause_time", 32'(cur_time), 32'd1);
    checkOutput("pause_running", 32'(running), 32'd0);
    waitUntil(s + 18);
    checkOutput("pause_frozen", 32'(cur_time), 32'd1);
    r = cyc + 1;
    pushExp(r + 1, 4'd2, 1'b1, 1'b0, 1'b0);
    pushExp(r + 5, 4'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 1, 0, 4'd0);
    checkOutput("resume_running", 32'(running), 32'd1);
    waitUntil(r + 6);
    checkOutput("resume_time", 32'(cur_time), 32'd3);
    checkOutput("pause_sb_empty", 32'(sbq.size()), 32'd0);

    // reset with start mid-count, then restart from DONE
    s = cyc + 1;
    for (int k = 1; k <= 5; k++) pushExp(s + 4 * k, 4'(k), 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1, 0, 0, 0, 4'd0);
    waitUntil(s + 21);
    checkOutput("pre_reset_time", 32'(cur_time), 32'd5);
    applyStimulus(1, 1, 0, 0, 1, 4'd9);
    checkOutput("rs_time", 32'(cur_time), 32'd0);
    checkOutput("rs_running", 32'(running), 32'd0);
    checkOutput("rs_tick", 32'(tick), 32'd0);
    checkOutput("rs_expired", 32'(expired), 32'd0);
    checkOutput("rs_done", 32'(done), 32'd0);
    s = cyc + 1;
    pushExp(s, 4'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(0, 1, 0, 0, 1, 4'd0);
    s = cyc + 1;
    pushExp(s + 4, 4'd1, 1'b1, 1'b0, 1'b0);
    pushExp(s + 8, 4'd2, 1'b1, 1'b1, 1'b1);
    applyStimulus(0, 1, 0, 0, 0, 4'd2);
    checkOutput("restart_running", 32'(running), 32'd1);
    checkOutput("restart_done", 32'(done), 32'd0);
    checkOutput("restart_time", 32'(cur_time), 32'd0);
    waitUntil(s + 10);
    checkOutput("restart_final", 32'(cur_time), 32'd2);
    checkOutput("restart_sb_empty", 32'(sbq.size()), 32'd0);

    // start wins over pause and resume in PAUSED
    s = cyc + 1;
    pushExp(s + 4, 4'd6, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1, 0, 0, 1, 4'd7);
    waitUntil(s + 5);
    applyStimulus(0, 0, 1, 0, 0, 4'd0);
    checkOutput("prio_paused", 32'(running), 32'd0);
    waitUntil(s + 9);
    s2 = cyc + 1;
    pushExp(s2 + 4, 4'd4, 1'b1, 1'b0, 1'b0);
    applyStimulus(0, 1, 1, 1, 1, 4'd5);
    checkOutput("prio_running", 32'(running), 32'd1);
    checkOutput("prio_load", 32'(cur_time), 32'd5);
    waitUntil(s2 + 5);
    checkOutput("prio_time", 32'(cur_time), 32'd4);
    checkOutput("prio_sb_empty", 32'(sbq.size()), 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
